// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one registered signed/unsigned magnitude comparator
// among NREQ requesters. Define CMP_SHARE_ARB_STATS_EN to add saturating result counters.
module cmp_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_signed,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [2:0]        rsp_o,
    output logic              busy
`ifdef CMP_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]       cnt_lt,
    output logic [15:0]       cnt_eq,
    output logic [15:0]       cnt_gt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   g_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            sgn_r;
    logic [2:0]      rsp_o_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic            busy_r;

    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   gnt_idx_s;
    logic            found_s;
    logic [IW:0]     sum_s;
    logic [IW-1:0]   cand_s;
    logic            resp_hs_s;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    function automatic logic [2:0] cmp_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
        logic [W-1:0] x;
        logic [W-1:0] y;
        x = a ^ {s, {(W-1){1'b0}}};
        y = b ^ {s, {(W-1){1'b0}}};
        if (x < y) begin
            return 3'b100;
        end else if (x == y) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Round-robin pick: first valid requester after the pointer, wrapping.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        cand_s    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum_s = {1'b0, ptr_r} + (IW+1)'(k);
            if (sum_s >= (IW+1)'(NREQ)) begin
                cand_s = IW'(sum_s - (IW+1)'(NREQ));
            end else begin
                cand_s = IW'(sum_s);
            end
            if (!found_s && req_valid[cand_s]) begin
                found_s   = 1'b1;
                gnt_idx_s = cand_s;
            end else begin
                found_s   = found_s;
            end
        end
        if (found_s) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // Accept strobe is only offered while idle and out of reset.
    always_comb begin
        if ((state_r == IDLE) && !rst) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    // Response handshake counts only the granted requester's ready.
    always_comb begin
        if (state_r == RESP) begin
            resp_hs_s = rsp_ready[g_r];
        end else begin
            resp_hs_s = 1'b0;
        end
    end

    // Main sequencer: grant/latch, compare, hold response until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= IW'(NREQ - 1);
            g_r         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sgn_r       <= 1'b0;
            rsp_o_r     <= 3'b000;
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        g_r     <= gnt_idx_s;
                        a_r     <= req_a[gnt_idx_s*W +: W];
                        b_r     <= req_b[gnt_idx_s*W +: W];
                        sgn_r   <= req_signed[gnt_idx_s];
                        busy_r  <= 1'b1;
                        state_r <= CMP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CMP: begin
                    rsp_o_r     <= cmp_f(a_r, b_r, sgn_r);
                    rsp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << g_r;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (resp_hs_s) begin
                        rsp_valid_r <= '0;
                        ptr_r       <= g_r;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= '0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_o     = rsp_o_r;
    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;

`ifdef CMP_SHARE_ARB_STATS_EN
    logic [15:0] cnt_lt_r;
    logic [15:0] cnt_eq_r;
    logic [15:0] cnt_gt_r;

    // Saturating per-result counters, bumped on each accepted response.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_lt_r <= 16'd0;
            cnt_eq_r <= 16'd0;
            cnt_gt_r <= 16'd0;
        end else if (resp_hs_s) begin
            case (rsp_o_r)
                3'b100:  cnt_lt_r <= sat_inc(cnt_lt_r);
                3'b010:  cnt_eq_r <= sat_inc(cnt_eq_r);
                3'b001:  cnt_gt_r <= sat_inc(cnt_gt_r);
                default: cnt_lt_r <= cnt_lt_r;
            endcase
        end else begin
            cnt_lt_r <= cnt_lt_r;
        end
    end

    assign cnt_lt = cnt_lt_r;
    assign cnt_eq = cnt_eq_r;
    assign cnt_gt = cnt_gt_r;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed self-checking bench for cmp_share_arbiter (NREQ=4, W=3); the counter
// section is compiled only when CMP_SHARE_ARB_STATS_EN is defined.
module tb_cmp_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_signed;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [2:0]        rsp_o;
    logic              busy;
`ifdef CMP_SHARE_ARB_STATS_EN
    logic [15:0]       cnt_lt;
    logic [15:0]       cnt_eq;
    logic [15:0]       cnt_gt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    cmp_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_o(rsp_o), .busy(busy)
`ifdef CMP_SHARE_ARB_STATS_EN
        , .cnt_lt(cnt_lt), .cnt_eq(cnt_eq), .cnt_gt(cnt_gt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [2:0] a, input logic [2:0] b, input logic s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_signed[i]   = s;
    endtask

    // One isolated request from requester i, response accepted immediately.
    task automatic run_one(input int i, input logic [2:0] a, input logic [2:0] b,
                           input logic s, input logic [2:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        @(negedge clk);
        req_valid    = 4'b0000;
        req_valid[i] = 1'b1;
        set_op(i, a, b, s);
        #1;
        check("grant", 16'(req_ready), 16'(oh));
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
        check("busy_cmp", 16'(busy), 16'd1);
        check("no_ready_cmp", 16'(req_ready), 16'd0);
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid", 16'(rsp_valid), 16'(oh));
        check("rsp_o", 16'(rsp_o), 16'(exp));
        rsp_ready = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", 16'(busy), 16'd0);
        check("idle_rsp_valid", 16'(rsp_valid), 16'd0);
        rsp_ready = 4'b0000;
    endtask

    logic [2:0] rr_exp [4];

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_a      = '0;
        req_b      = '0;
        req_signed = 4'b0000;
        rsp_ready  = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 16'(req_ready), 16'd0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_rsp_o", 16'(rsp_o), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);

        // Unsigned single request, then signed/unsigned pairs.
        run_one(0, 3'd5, 3'd2, 1'b0, 3'b001);
        run_one(1, 3'b111, 3'b001, 1'b1, 3'b100);
        run_one(2, 3'b111, 3'b001, 1'b0, 3'b001);
        run_one(0, 3'b100, 3'b100, 1'b0, 3'b010);
        run_one(1, 3'b011, 3'b100, 1'b1, 3'b001);
        run_one(3, 3'b100, 3'b100, 1'b1, 3'b010);

        // Round robin from pointer 3: grants 0,1,2,3,0 every 3 cycles.
        rr_exp[0] = 3'b100;
        rr_exp[1] = 3'b100;
        rr_exp[2] = 3'b010;
        rr_exp[3] = 3'b001;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_op(i, 3'(i), 3'd2, 1'b0);
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            check("rr_grant", 16'(req_ready), 16'(4'b0001 << (n % 4)));
            @(posedge clk);
            @(negedge clk);
            check("rr_busy_ready", 16'(req_ready), 16'd0);
            check("rr_busy", 16'(busy), 16'd1);
            @(posedge clk);
            @(negedge clk);
            check("rr_rsp_valid", 16'(rsp_valid), 16'(4'b0001 << (n % 4)));
            check("rr_rsp_o", 16'(rsp_o), 16'(rr_exp[n % 4]));
            check("rr_resp_ready", 16'(req_ready), 16'd0);
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;

        // Backpressure on requester 1, others waiting.
        @(negedge clk);
        set_op(1, 3'd2, 3'd5, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("bp_grant1", 16'(req_ready), 16'b0010);
        @(posedge clk);
        @(negedge clk);
        set_op(0, 3'd1, 3'd1, 1'b0);
        set_op(3, 3'd5, 3'd4, 1'b0);
        req_valid = 4'b1001;
        @(posedge clk);
        @(negedge clk);
        check("bp_rsp_valid", 16'(rsp_valid), 16'b0010);
        check("bp_rsp_o", 16'(rsp_o), 16'b100);
        rsp_ready = 4'b1101;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 16'(rsp_valid), 16'b0010);
            check("bp_hold_o", 16'(rsp_o), 16'b100);
            check("bp_no_grant", 16'(req_ready), 16'd0);
        end
        rsp_ready = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        check("bp_released", 16'(rsp_valid), 16'd0);
        check("bp_next_grant3", 16'(req_ready), 16'b1000);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        check("bp3_rsp_valid", 16'(rsp_valid), 16'b1000);
        check("bp3_rsp_o", 16'(rsp_o), 16'b001);
        @(posedge clk);
        @(negedge clk);
        check("wrap_grant0", 16'(req_ready), 16'b0001);

        // Reset while requester 0's compare is in CMP.
        set_op(0, 3'd0, 3'b111, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("mid_rst_rsp_o", 16'(rsp_o), 16'd0);
        check("mid_rst_ready", 16'(req_ready), 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_grant0", 16'(req_ready), 16'b0001);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        check("post_rst_no_rsp", 16'(rsp_valid), 16'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_rsp_valid", 16'(rsp_valid), 16'b0001);
        check("post_rst_rsp_o", 16'(rsp_o), 16'b001);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", 16'(busy), 16'd0);
        rsp_ready = 4'b0000;

`ifdef CMP_SHARE_ARB_STATS_EN
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("cnt_rst", 16'(cnt_lt | cnt_eq | cnt_gt), 16'd0);
        run_one(1, 3'd1, 3'd2, 1'b0, 3'b100);
        run_one(2, 3'd3, 3'd3, 1'b0, 3'b010);
        run_one(3, 3'd3, 3'd3, 1'b1, 3'b010);
        check("cnt_lt", cnt_lt, 16'd1);
        check("cnt_eq", cnt_eq, 16'd2);
        check("cnt_gt", cnt_gt, 16'd0);
        force dut.cnt_gt_r = 16'hFFFF;
        #1;
        release dut.cnt_gt_r;
        run_one(0, 3'd6, 3'd1, 1'b0, 3'b001);
        check("cnt_gt_sat", cnt_gt, 16'hFFFF);
        check("cnt_lt_keep", cnt_lt, 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
